// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle between the fetch unit and its environment.
// master (fetch unit): drives imem_req/imem_addr, instr_valid/instr/instr_pc, fetch_err;
//                      samples imem_rvalid/imem_rdata, redirect/redirect_pc, instr_ready.
// slave (memory + datapath): the mirror image of master.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rvalid;
   logic [31:0]       imem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              instr_valid;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;
   logic              fetch_err;
   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
      input  imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );
   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
      output imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing one-at-a-time word fetches and handing instructions to the datapath.
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : master side of instr_fetch_unit_if (imem request/response, redirect, instr handshake, fetch_err)
module instr_fetch_unit #(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
   input logic                 clk,
   input logic                 reset,
   instr_fetch_unit_if.master  bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, instr_pc_q, instr_pc_d;
   logic [31:0]       instr_q, instr_d;
   logic              drop_q, drop_d, req_q, req_d, valid_q, valid_d, err_q, err_d;
   logic              redir_ok, redir_bad;
   assign redir_ok  = bus.redirect && (bus.redirect_pc[1:0] == 2'b00);
   assign redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      err_d      = err_q;
      if (state_q != ERR && redir_bad) begin
         state_d = ERR;
         err_d   = 1'b1;
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         drop_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
               pc_d    = redir_ok ? bus.redirect_pc : pc_q;
            end
            // the request at the old pc is already on the bus; its response must be dropped
            REQ: begin
               state_d = WAIT;
               pc_d    = redir_ok ? bus.redirect_pc : pc_q;
               drop_d  = redir_ok;
            end
            WAIT: begin
               if (redir_ok) begin
                  pc_d    = bus.redirect_pc;
                  drop_d  = !bus.imem_rvalid;
                  state_d = bus.imem_rvalid ? REQ : WAIT;
               end else if (bus.imem_rvalid && drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else if (bus.imem_rvalid) begin
                  instr_d    = bus.imem_rdata;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  pc_d       = pc_q + ADDR_W'(4);
                  state_d    = HOLD;
               end
            end
            // a redirect squashes the held instruction even when the datapath is ready
            HOLD: begin
               if (redir_ok || bus.instr_ready) begin
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
                  pc_d    = redir_ok ? bus.redirect_pc : pc_q;
                  state_d = REQ;
               end
            end
            default: ;
         endcase
      end
   end
   // request strobe and address are registered on entry to REQ so they are glitch-free
   assign req_d  = (state_d == REQ);
   assign addr_d = req_d ? pc_d : addr_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         instr_pc_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         err_q      <= err_d;
      end
   end
   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.fetch_err   = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks of instr_fetch_unit against a transaction-level model.
module tb_instr_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef struct {logic [31:0] pc; logic [31:0] ins; int cyc;} acc_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   instr_fetch_unit_if #(.ADDR_W(32)) bus();
   instr_fetch_unit_if #(.ADDR_W(32)) wbus();
   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (.clk(clk), .reset(reset), .bus(bus));
   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) wdut (.clk(clk), .reset(reset), .bus(wbus));
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lat = 1;
   // model: what the fetch unit is doing, as flags rather than states
   logic [31:0] m_pc, m_addr, m_instr, m_ipc;
   logic        m_req, m_valid, m_err, m_dead, m_wait, m_stale;
   // memory
   logic        mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;
   logic        w_prev_req;
   logic [31:0] w_prev_addr;
   // last sampled outputs
   logic [31:0] s_addr, s_instr, s_ipc;
   logic        s_req, s_valid, s_err;
   acc_t        acc[$];
   acc_t        wq[$];
   logic [31:0] reqs[$];
   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0030_0113;
      if (a == 32'h8) return 32'h0020_81B3;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask
   task automatic m_reset();
      m_pc = 32'h0; m_addr = 32'h0; m_instr = NOP; m_ipc = 32'h0;
      m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_dead = 1'b0; m_wait = 1'b0; m_stale = 1'b0;
   endtask
   task automatic model_step();
      logic gr, br;
      gr = bus.redirect && bus.redirect_pc[1:0] == 2'b00;
      br = bus.redirect && !gr;
      if (m_dead) return;
      if (br) begin
         m_dead = 1'b1; m_err = 1'b1; m_valid = 1'b0; m_instr = NOP; m_req = 1'b0; m_wait = 1'b0; m_stale = 1'b0;
         return;
      end
      if (m_req) begin
         m_req = 1'b0; m_wait = 1'b1;
         if (gr) begin m_pc = bus.redirect_pc; m_stale = 1'b1; end
      end else if (m_wait) begin
         if (bus.imem_rvalid) begin
            m_wait = 1'b0;
            if (gr || m_stale) begin
               m_stale = 1'b0;
               if (gr) m_pc = bus.redirect_pc;
               m_req = 1'b1; m_addr = m_pc;
            end else begin
               m_valid = 1'b1; m_instr = bus.imem_rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
            end
         end else if (gr) begin
            m_pc = bus.redirect_pc; m_stale = 1'b1;
         end
      end else if (m_valid) begin
         if (gr || bus.instr_ready) begin
            m_valid = 1'b0; m_instr = NOP;
            if (gr) m_pc = bus.redirect_pc;
            m_req = 1'b1; m_addr = m_pc;
         end
      end else begin
         if (gr) m_pc = bus.redirect_pc;
         m_req = 1'b1; m_addr = m_pc;
      end
   endtask
   task automatic idle_inputs();
      bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
      wbus.redirect = 1'b0; wbus.redirect_pc = 32'h0; wbus.instr_ready = 1'b1;
      wbus.imem_rvalid = 1'b0; wbus.imem_rdata = 32'h0;
   endtask
   task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
      @(negedge clk);
      cyc++;
      s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = bus.instr_valid;
      s_instr = bus.instr; s_ipc = bus.instr_pc; s_err = bus.fetch_err;
      chk("imem_req", {31'b0, s_req}, {31'b0, m_req});
      if (m_req) chk("imem_addr", s_addr, m_addr);
      chk("instr_valid", {31'b0, s_valid}, {31'b0, m_valid});
      chk("instr", s_instr, m_instr);
      chk("instr_pc", s_ipc, m_ipc);
      chk("fetch_err", {31'b0, s_err}, {31'b0, m_err});
      chk("one_outstanding", {31'b0, s_req & mem_busy}, 32'h0);
      if (s_req) reqs.push_back(s_addr);
      if (s_valid && rdy && !rd) acc.push_back('{s_ipc, s_instr, cyc});
      if (mem_busy && mem_cnt == 1) begin
         bus.imem_rvalid = 1'b1; bus.imem_rdata = rom(mem_addr); mem_busy = 1'b0;
      end else begin
         bus.imem_rvalid = 1'b0; bus.imem_rdata = $urandom;
         if (mem_busy) mem_cnt--;
      end
      if (s_req) begin
         mem_busy = 1'b1; mem_addr = s_addr;
         mem_cnt = (lat != 0) ? lat : int'($urandom_range(1, 4));
      end
      bus.redirect = rd; bus.redirect_pc = rpc; bus.instr_ready = rdy;
      if (wbus.instr_valid) wq.push_back('{wbus.instr_pc, wbus.instr, cyc});
      wbus.imem_rvalid = w_prev_req; wbus.imem_rdata = ~w_prev_addr;
      w_prev_req = wbus.imem_req; w_prev_addr = wbus.imem_addr;
      @(posedge clk);
      if (reset) model_step();
   endtask
   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      mem_busy = 1'b0; w_prev_req = 1'b0; w_prev_addr = 32'h0;
      m_reset();
      @(posedge clk);
      model_step();
   endtask
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
      chk("arst_addr", bus.imem_addr, 32'h0);
      chk("arst_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("arst_instr", bus.instr, NOP);
      chk("arst_ipc", bus.instr_pc, 32'h0);
      chk("arst_err", {31'b0, bus.fetch_err}, 32'h0);
      m_reset();
      mem_busy = 1'b0;
      @(posedge clk);
      #1 chk("arst_hold_req", {31'b0, bus.imem_req}, 32'h0);
      release_reset();
   endtask
   task automatic run_until_accept(input string n);
      int k;
      k = 0;
      while (acc.size() == 0 && k < 40) begin
         step(1'b0, 32'h0, 1'b1);
         k++;
      end
      chk({n, "_accept_seen"}, {31'b0, acc.size() != 0}, 32'h1);
   endtask
   initial begin
      int k;
      logic [31:0] rpc;
      idle_inputs();
      m_reset();
      mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0; w_prev_req = 1'b0; w_prev_addr = 32'h0;
      @(negedge clk);
      chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
      chk("rst_addr", bus.imem_addr, 32'h0);
      chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("rst_instr", bus.instr, NOP);
      chk("rst_ipc", bus.instr_pc, 32'h0);
      chk("rst_err", {31'b0, bus.fetch_err}, 32'h0);
      // free-run, latency 1, always ready
      lat = 1;
      release_reset();
      acc.delete(); wq.delete();
      for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 1'b1);
      chk("free_count", acc.size(), 32'd3);
      if (acc.size() == 3) begin
         chk("free_pc0", acc[0].pc, 32'h0);   chk("free_in0", acc[0].ins, 32'h0050_0093);
         chk("free_pc1", acc[1].pc, 32'h4);   chk("free_in1", acc[1].ins, 32'h0030_0113);
         chk("free_pc2", acc[2].pc, 32'h8);   chk("free_in2", acc[2].ins, 32'h0020_81B3);
         chk("free_rate", acc[1].cyc - acc[0].cyc, 32'd3);
      end
      chk("wrap_count", {31'b0, wq.size() >= 2}, 32'h1);
      if (wq.size() >= 2) begin
         chk("wrap_pc0", wq[0].pc, 32'hFFFF_FFFC);
         chk("wrap_in0", wq[0].ins, 32'h0000_0003);
         chk("wrap_pc1", wq[1].pc, 32'h0);
      end
      // backpressure while holding pc 0xC
      acc.delete();
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'h0, 1'b0);
         chk("bp_valid", {31'b0, s_valid}, 32'h1);
         chk("bp_req", {31'b0, s_req}, 32'h0);
         chk("bp_ipc", s_ipc, 32'hC);
         chk("bp_instr", s_instr, rom(32'hC));
      end
      step(1'b0, 32'h0, 1'b1);
      chk("bp_accept", {31'b0, acc.size() == 1}, 32'h1);
      if (acc.size() == 1) chk("bp_accept_pc", acc[0].pc, 32'hC);
      // redirect during WAIT, latency 3
      lat = 3;
      acc.delete(); reqs.delete();
      step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'h40, 1'b1);
      run_until_accept("rw");
      chk("rw_req_cnt", {31'b0, reqs.size() >= 2}, 32'h1);
      if (reqs.size() >= 2) begin
         chk("rw_req0", reqs[0], 32'h10);
         chk("rw_req1", reqs[1], 32'h40);
      end
      if (acc.size() != 0) begin
         chk("rw_pc", acc[0].pc, 32'h40);
         chk("rw_instr", acc[0].ins, rom(32'h40));
      end
      // redirect coincident with the response
      lat = 1;
      k = 0;
      while (!m_req && k < 10) begin step(1'b0, 32'h0, 1'b1); k++; end
      acc.delete();
      step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'h80, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("rv_valid", {31'b0, s_valid}, 32'h0);
      chk("rv_req", {31'b0, s_req}, 32'h1);
      chk("rv_addr", s_addr, 32'h80);
      run_until_accept("rv");
      if (acc.size() != 0) chk("rv_pc", acc[0].pc, 32'h80);
      // redirect coincident with a HOLD handshake
      k = 0;
      while (!m_valid && k < 10) begin step(1'b0, 32'h0, 1'b0); k++; end
      acc.delete();
      step(1'b1, 32'hC0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("rh_valid", {31'b0, s_valid}, 32'h0);
      chk("rh_req", {31'b0, s_req}, 32'h1);
      chk("rh_addr", s_addr, 32'hC0);
      run_until_accept("rh");
      if (acc.size() != 0) chk("rh_pc", acc[0].pc, 32'hC0);
      // randomized traffic
      lat = 0;
      for (int i = 0; i < 600; i++) begin
         rpc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 63)) * 32'd4;
         step($urandom_range(0, 7) == 0, rpc, $urandom_range(0, 9) < 7);
      end
      // misaligned redirect locks the unit in error
      step(1'b1, 32'h42, 1'b1);
      reqs.delete();
      for (int i = 0; i < 12; i++) step($urandom_range(0, 2) == 0, 32'h100, 1'b1);
      chk("err_no_req", reqs.size(), 32'd0);
      chk("err_flag", {31'b0, s_err}, 32'h1);
      chk("err_valid", {31'b0, s_valid}, 32'h0);
      async_reset();
      // asynchronous reset in the middle of WAIT
      lat = 3;
      step(1'b0, 32'h0, 1'b1);
      async_reset();
      lat = 1;
      acc.delete();
      run_until_accept("restart");
      if (acc.size() != 0) begin
         chk("restart_pc", acc[0].pc, 32'h0);
         chk("restart_instr", acc[0].ins, 32'h0050_0093);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage for the single-cycle RISC-V datapath.
- Owns the program counter and issues one-at-a-time word requests to a variable-latency instruction memory.
- Presents each fetched instruction and its PC to the datapath over a valid/ready handshake.
- Accepts branch/jump redirects from the datapath and squashes any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, width of PC and memory address.
- NOP_INSTR, 32'h0000_0013, value driven on instr while no instruction is valid (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; the block is in reset while reset is low.
- imem_req  out  1  single-cycle request strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the request; valid only while imem_req=1.
- imem_rvalid  in  1  memory response valid; exactly one response per request, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word; sampled only when imem_rvalid=1.
- redirect  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  target PC, sampled when redirect=1.
- instr_valid  out  1  instr/instr_pc hold a valid fetched instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  ADDR_W  PC of instr.
- instr_ready  in  1  datapath accepts instr this cycle.
- fetch_err  out  1  sticky flag: misaligned redirect target received.

Behaviour:
- Reset values while reset=0:
  - pc=RESET_PC, state=IDLE, drop=0
  - imem_req=0, imem_addr=0
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0
  - fetch_err=0
- Reset is honoured asynchronously at any point, including mid-fetch. A response arriving after reset is released is ignored unless the unit is in WAIT.
- FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: entered on reset; advances to REQ on the next cycle.
- REQ: drives imem_req=1 and imem_addr=pc for exactly one cycle, then goes to WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - drop=1: discard the response, clear drop, go to REQ.
  - drop=0: latch instr=imem_rdata and instr_pc=pc, set instr_valid=1, pc<=pc+4, go to HOLD.
- HOLD:
  - instr, instr_pc and instr_valid stay stable until instr_valid&instr_ready.
  - On the handshake, instr_valid goes to 0 and instr goes to NOP_INSTR next cycle; state goes to REQ.
  - Minimum cycles per instruction with 1-cycle memory: 3 (REQ, WAIT, HOLD).
- PC arithmetic: pc+4 is modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0x0000_0000. The PC is never incremented on a discarded response.
- Redirect has priority over all other events and loads pc<=redirect_pc. Per state:
  - IDLE: go to REQ.
  - REQ: the request at the old pc still issues this cycle; set drop=1; go to WAIT.
  - WAIT without imem_rvalid: set drop=1; stay in WAIT.
  - WAIT with imem_rvalid in the same cycle: discard the response; drop=0; go to REQ.
  - HOLD: squash the held instruction (instr_valid=0 next cycle) even if instr_ready=1 that cycle; go to REQ.
- Misaligned redirect (redirect=1 and redirect_pc[1:0]!=0):
  - Set fetch_err=1, instr_valid=0; go to ERR.
  - ERR issues no requests, ignores responses and redirects, and is left only by reset.
- Only one request is ever outstanding. imem_req is never asserted in WAIT, HOLD or ERR.

Test Plan:
- Reset then free-run, memory latency 1, instr_ready=1, ROM[0..2]=0x00500093,0x00300113,0x002081B3 → accepted (instr_pc, instr) = (0x0, 0x00500093), (0x4, 0x00300113), (0x8, 0x002081B3); one instruction every 3 cycles.
- Backpressure: instr_ready=0 for 5 cycles while in HOLD → instr/instr_pc stable, instr_valid=1, imem_req=0 throughout; accepted once ready rises.
- Redirect during WAIT, memory latency 3, redirect_pc=0x40 → response for the old PC discarded, next request at 0x40, next delivered instr_pc=0x40.
- Redirect coincident with imem_rvalid, and redirect coincident with a HOLD handshake → both squashed, instr_valid=0 next cycle, next fetch at redirect_pc.
- Wrap: RESET_PC=0xFFFF_FFFC → first instr_pc=0xFFFF_FFFC, second instr_pc=0x0000_0000.
- redirect_pc=0x42 → fetch_err=1, no further imem_req; reset low mid-WAIT → all outputs at reset values asynchronously; after release, fetching restarts at RESET_PC.
